ram_1port_selftest: RTL and testbench
=====================================

# ram_1port_selftest

Parametrised single-port RAM self-test engine, successor to the fixed 32×8 write-then-read RAM exerciser. It owns one single-port RAM instance and fills every address with a selectable pattern. It then reads every address back, compares against the recomputed expectation, and reports pass/fail, error count and first failing address. It sits beside the RAM IP blocks as a bring-up and BIST unit and is triggered by a one-cycle start pulse.

## Interface
- `DATA_W`, default 8: RAM word width, range 1..64.
- `DEPTH`, default 32: number of words, ≥2.
- `ADDR_W`, default `$clog2(DEPTH)`: derived; not overridden.

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `mode`  in  2  pattern select; latched at accepted start.
- `inj_en`  in  1  fault-injection enable; latched at start.
- `inj_addr`  in  ADDR_W  address whose written word gets bit 0 inverted; latched at start.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  last run had zero mismatches.
- `err_cnt`  out  ADDR_W+1  mismatch count of last run.
- `err_addr`  out  ADDR_W  first mismatching address of last run; 0 if none.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE → WRITE on `start`=1. On the same edge: latch `mode`/`inj_*`, clear `err_cnt`, `err_addr`, `pass`.
- WRITE: address counter runs 0..DEPTH-1, one write per cycle. At DEPTH-1 → READ with the counter reset to 0.
- READ: one read issued per cycle over addresses 0..DEPTH-1. At DEPTH-1 → DRAIN.
- DRAIN: one cycle, compares the last read. Then → DONE.
- DONE: `done`=1 for one cycle; `pass` = (`err_cnt`==0). Then → IDLE.
- Pattern `pat(a)` is a pure function of address; `a` is zero-extended or truncated to DATA_W:
  - mode 0: `a`
  - mode 1: `~a`
  - mode 2: all-0101… when `a[0]`=0, all-1010… when `a[0]`=1 (LSB of the first word is 1)
  - mode 3: walking one, `1 << (a mod DATA_W)`
- Write data is `pat(a)`, with bit 0 inverted when `inj_en` and `a`==`inj_addr`.
- Compare: read data vs `pat(a_d)`, where `a_d` is the read address delayed one cycle. On mismatch `err_cnt` increments. On the first mismatch only, `err_addr` ← `a_d`.
- `err_cnt` cannot overflow; its maximum is DEPTH.
- `start` outside IDLE is ignored. Holding `start` high re-triggers only once back in IDLE.
- `mode`/`inj_*` changes during a run have no effect.
- `sys_rst` mid-run: next edge → IDLE. `busy`, `done`, `pass`, `err_cnt`, `err_addr` go to 0, and no `done` is emitted. RAM contents are not cleared.
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `err_addr`=0.

## Timing
- Start accepted at edge 0.
- WRITE covers cycles 1..DEPTH.
- READ covers cycles DEPTH+1..2·DEPTH.
- DRAIN is cycle 2·DEPTH+1.
- `done` is high in cycle 2·DEPTH+2 (66 for DEPTH=32).
- `busy` is high in cycles 1..2·DEPTH+1 and low in the `done` cycle.
- RAM read latency is 1 cycle (registered output). Compares therefore occur in cycles DEPTH+2..2·DEPTH+1.
- `pass`, `err_cnt` and `err_addr` are final when `done` rises. They hold until the next accepted start.
- Earliest restart: `start` sampled in the cycle after `done`.

## Structure
- Package `ram_test_pkg` holds:
  - state enum `st_e`
  - mode constants `MODE_INC`, `MODE_INV`, `MODE_CHK`, `MODE_WALK`
  - function `pat_gen(addr, mode)`, parametrised through width arguments
- Sub-module `sp_ram` (`DATA_W`, `DEPTH`): single port with `clk`, `we`, `addr`, `wdata`, `rdata`. Registered read, read-first on simultaneous access, no reset on contents.

## Test plan
- DATA_W=8, DEPTH=32: reset, then `start`, mode 0 → `done` exactly 66 cycles after the start edge, `pass`=1, `err_cnt`=0, `busy` high 65 cycles.
- mode 0, `inj_en`=1, `inj_addr`=5 → RAM[5]=0x04, `err_cnt`=1, `err_addr`=5, `pass`=0.
- mode 3 with `inj_en`=0 → RAM[9]=0x02, RAM[31]=0x80, `pass`=1. Then mode 2 → RAM[0]=0x55, RAM[1]=0xAA, `pass`=1.
- `start` held high for 200 cycles → back-to-back runs, each `done` exactly 67 cycles apart. Pulse `start` at cycle 10 of a run → ignored, single `done`.
- `sys_rst` asserted at cycle 40 (READ) → all outputs 0 on the next edge and no `done`. A following start completes with `pass`=1.
- DATA_W=12, DEPTH=16, mode 1, `inj_addr`=15 → `done` at cycle 34, RAM[3]=0xFFC, `err_cnt`=1, `err_addr`=15.

Source files
------------

// File: rtl/ram_test_pkg.sv
// ram_test_pkg: FSM states, pattern modes and the address-to-pattern function shared by the self-test
package ram_test_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} st_e;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_CHK  = 2'd2;
    localparam logic [1:0] MODE_WALK = 2'd3;

    // Result is 64 bits wide; callers truncate to their word width, dw only steers the walking one
    function automatic logic [63:0] pat_gen(input logic [63:0] addr, input logic [1:0] mode, input int dw);
        return mode == MODE_INC ? addr :
               mode == MODE_INV ? ~addr :
               mode == MODE_CHK ? (addr[0] ? {32{2'b10}} : {32{2'b01}}) :
               64'd1 << (addr % 64'(dw));
    endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port RAM with registered, read-first output and no reset on contents
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_1port_selftest.sv
// ram_1port_selftest: fills a single-port RAM with a pattern, reads it back and reports mismatches
module ram_1port_selftest
    import ram_test_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    st_e               st, st_nxt;
    logic [ADDR_W-1:0] addr, a_d, inj_addr_r;
    logic [1:0]        mode_r;
    logic              inj_en_r, rd_vld, we, mis, at_last;
    logic [DATA_W-1:0] wdata, rdata, exp_d;
    logic [ADDR_W:0]   err_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) st <= ST_IDLE;
        else         st <= st_nxt;
    end

    always_comb begin
        at_last = addr == LAST;
        st_nxt  = st == ST_IDLE  ? (start   ? ST_WRITE : ST_IDLE)  :
                  st == ST_WRITE ? (at_last ? ST_READ  : ST_WRITE) :
                  st == ST_READ  ? (at_last ? ST_DRAIN : ST_READ)  :
                  st == ST_DRAIN ? ST_DONE : ST_IDLE;
    end

    always_comb begin
        busy = st == ST_WRITE || st == ST_READ || st == ST_DRAIN;
        done = st == ST_DONE;
        we   = st == ST_WRITE;
    end

    // Compare runs one cycle behind the read address to match the registered RAM output
    always_comb begin
        wdata   = DATA_W'(pat_gen(64'(addr), mode_r, DATA_W)) ^ DATA_W'(inj_en_r && addr == inj_addr_r);
        exp_d   = DATA_W'(pat_gen(64'(a_d), mode_r, DATA_W));
        mis     = rd_vld && rdata != exp_d;
        err_nxt = err_cnt + (ADDR_W + 1)'(mis);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr       <= '0;
            a_d        <= '0;
            rd_vld     <= 1'b0;
            mode_r     <= '0;
            inj_en_r   <= 1'b0;
            inj_addr_r <= '0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            err_addr   <= '0;
        end else begin
            a_d    <= addr;
            rd_vld <= st == ST_READ;
            addr   <= (st == ST_WRITE || st == ST_READ) ? (at_last ? '0 : addr + ADDR_W'(1)) : addr;
            if (st == ST_IDLE && start) begin
                mode_r     <= mode;
                inj_en_r   <= inj_en;
                inj_addr_r <= inj_addr;
                pass       <= 1'b0;
                err_cnt    <= '0;
                err_addr   <= '0;
            end
            if (mis) begin
                err_cnt <= err_nxt;
                if (err_cnt == '0) err_addr <= a_d;
            end
            if (st == ST_DRAIN) pass <= err_nxt == '0;
        end
    end

    sp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (sys_clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ram_1port_selftest.sv
// tb_ram_1port_selftest: directed runs checked against a run-timeline model plus literal expectations
module tb_ram_1port_selftest;

    localparam int W = 8, D = 32, AW = 5;
    localparam int W2 = 12, D2 = 16, AW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, start = 1'b0, inj_en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] inj_addr = '0;
    logic          busy, done, pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] err_addr;

    logic           b_start = 1'b0, b_inj_en = 1'b0;
    logic [1:0]     b_mode = 2'd0;
    logic [AW2-1:0] b_inj_addr = '0;
    logic           b_busy, b_done, b_pass;
    logic [AW2:0]   b_err_cnt;
    logic [AW2-1:0] b_err_addr;

    ram_1port_selftest #(.DATA_W(W), .DEPTH(D)) dut (
        .sys_clk(clk), .sys_rst(rst), .start(start), .mode(mode), .inj_en(inj_en),
        .inj_addr(inj_addr), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .err_addr(err_addr)
    );

    ram_1port_selftest #(.DATA_W(W2), .DEPTH(D2)) dut2 (
        .sys_clk(clk), .sys_rst(rst), .start(b_start), .mode(b_mode), .inj_en(b_inj_en),
        .inj_addr(b_inj_addr), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err_cnt), .err_addr(b_err_addr)
    );

    int total = 0, bad = 0, cyc = 0;
    bit chk_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic longint mpat(int a, int m, int w);
        longint mask = (longint'(1) << w) - 1;
        longint r = 0;
        if (m == 0) r = a & mask;
        else if (m == 1) r = mask ^ (a & mask);
        else if (m == 2) begin
            for (int b = 0; b < w; b++) if ((b % 2) == (a % 2)) r |= longint'(1) << b;
        end else r = longint'(1) << (a % w);
        return r;
    endfunction

    function automatic longint wr(int a, int m, int ie, int ia, int w);
        return mpat(a, m, w) ^ longint'((ie != 0 && a == ia) ? 1 : 0);
    endfunction

    function automatic int nerr(int m, int ie, int ia);
        int n = 0;
        for (int a = 0; a < D; a++) if (wr(a, m, ie, ia, W) != mpat(a, m, W)) n++;
        return n;
    endfunction

    function automatic int ferr(int m, int ie, int ia);
        for (int a = 0; a < D; a++) if (wr(a, m, ie, ia, W) != mpat(a, m, W)) return a;
        return 0;
    endfunction

    // Model: t counts cycles since the accepted start (0 = idle); outcome is known at start
    int     t = 0;
    longint e_pass = 0, e_cnt = 0, e_addr = 0, f_pass = 0, f_cnt = 0, f_addr = 0;
    longint m_img [D];

    always @(posedge clk) begin
        if (rst) begin
            t <= 0; e_pass <= 0; e_cnt <= 0; e_addr <= 0;
        end else if (t == 0) begin
            if (start) begin
                t <= 1; e_pass <= 0; e_cnt <= 0; e_addr <= 0;
                f_cnt  <= nerr(mode, inj_en, inj_addr);
                f_addr <= ferr(mode, inj_en, inj_addr);
                f_pass <= nerr(mode, inj_en, inj_addr) == 0;
                for (int a = 0; a < D; a++) m_img[a] <= wr(a, mode, inj_en, inj_addr, W);
            end
        end else if (t == 2 * D + 2) t <= 0;
        else begin
            t <= t + 1;
            if (t == 2 * D + 1) begin
                e_pass <= f_pass; e_cnt <= f_cnt; e_addr <= f_addr;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("busy", busy, (t >= 1 && t <= 2 * D + 1) ? 1 : 0);
        check("done", done, (t == 2 * D + 2) ? 1 : 0);
        if (t == 0 || t == 2 * D + 2) begin
            check("pass", pass, e_pass);
            check("err_cnt", err_cnt, e_cnt);
            check("err_addr", err_addr, e_addr);
        end
    end

    task automatic start_a(input int m, input bit ie, input int ia, output int c0);
        @(negedge clk);
        mode = 2'(m); inj_en = ie; inj_addr = AW'(ia); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic run_a(input int m, input bit ie, input int ia, output int k, output int nb);
        int c0;
        start_a(m, ie, ia, c0);
        k = -1;
        nb = busy ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                k = cyc - c0 + 1;
                break;
            end
            if (busy) nb++;
        end
        if (k < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within 200 cycles");
        end
    endtask

    task automatic check_img();
        for (int a = 0; a < D; a++) check($sformatf("ram[%0d]", a), dut.u_ram.mem[a], m_img[a]);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nb, c0, nd, prev;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_addr", err_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        run_a(0, 0, 0, k, nb);
        check("m0_latency", k, 66);
        check("m0_busy_cycles", nb, 65);
        check("m0_pass", pass, 1);
        check("m0_err_cnt", err_cnt, 0);
        check_img();

        run_a(0, 1, 5, k, nb);
        check("inj_ram5", dut.u_ram.mem[5], 'h04);
        check("inj_err_cnt", err_cnt, 1);
        check("inj_err_addr", err_addr, 5);
        check("inj_pass", pass, 0);
        check_img();

        run_a(3, 0, 0, k, nb);
        check("walk_ram9", dut.u_ram.mem[9], 'h02);
        check("walk_ram31", dut.u_ram.mem[31], 'h80);
        check("walk_pass", pass, 1);
        check_img();

        run_a(2, 0, 0, k, nb);
        check("chk_ram0", dut.u_ram.mem[0], 'h55);
        check("chk_ram1", dut.u_ram.mem[1], 'hAA);
        check("chk_pass", pass, 1);
        check_img();

        @(negedge clk);
        mode = 2'd0; inj_en = 1'b0; start = 1'b1;
        prev = -1; nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                if (prev >= 0) check("held_gap", cyc - prev, 67);
                prev = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("held_runs", nd >= 2 ? 1 : 0, 1);
        wait_idle();

        start_a(1, 0, 0, c0);
        nd = 0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (done) nd++;
            @(negedge clk);
        end
        check("midrun_start_dones", nd, 1);

        start_a(0, 0, 0, c0);
        repeat (39) @(negedge clk);
        check("rst40_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst40_busy", busy, 0);
        check("rst40_done", done, 0);
        check("rst40_pass", pass, 0);
        check("rst40_err_cnt", err_cnt, 0);
        check("rst40_err_addr", err_addr, 0);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst40_no_done", nd, 0);
        run_a(0, 0, 0, k, nb);
        check("after_rst_latency", k, 66);
        check("after_rst_pass", pass, 1);

        @(negedge clk);
        b_mode = 2'd1; b_inj_en = 1'b1; b_inj_addr = 4'd15; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        c0 = cyc;
        k = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_done) begin
                k = cyc - c0 + 1;
                break;
            end
        end
        check("w12_latency", k, 34);
        check("w12_ram3", dut2.u_ram.mem[3], 'hFFC);
        check("w12_ram15", dut2.u_ram.mem[15], 'hFF1);
        check("w12_err_cnt", b_err_cnt, 1);
        check("w12_err_addr", b_err_addr, 15);
        check("w12_pass", b_pass, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
